// File: rtl/cdb_arbiter.sv
// Common data bus arbiter for the LEN5 execution pipeline.
// Picks at most one execution-unit result per cycle with rotating priority,
// registers it, and broadcasts it to the ROB and reservation stations.

package cdb_pkg;

  localparam int unsigned ROB_IDX_LEN = 4;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned EXCEPT_W    = 4;

  typedef struct packed {
    logic [ROB_IDX_LEN-1:0] rob_idx;
    logic [XLEN-1:0]        res_value;
    logic                   except_raised;
    logic [EXCEPT_W-1:0]    except_code;
  } cdb_data_t;

endpackage

module cdb_arbiter #(
  parameter int unsigned EU_N  = 7,
  parameter int unsigned CDB_W = $bits(cdb_pkg::cdb_data_t)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [EU_N-1:0]            eu_valid_i,
  output logic [EU_N-1:0]            eu_ready_o,
  input  logic [EU_N-1:0][CDB_W-1:0] eu_data_i,
  output logic                       cdb_valid_o,
  input  logic                       cdb_ready_i,
  output logic [CDB_W-1:0]           cdb_data_o
);

  // A single requester still needs a one-bit pointer to keep the vectors legal.
  localparam int unsigned PTR_W = (EU_N > 1) ? $clog2(EU_N) : 1;

  logic [PTR_W-1:0] rr_ptr_q;
  logic             cdb_valid_q;
  logic [CDB_W-1:0] cdb_data_q;

  logic             can_load;
  logic             load_ok;
  logic             transfer;
  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W:0]   search_sum;
  logic [PTR_W-1:0] search_idx;

  // The output register is free when empty or when its content leaves this cycle.
  assign can_load = !cdb_valid_q || cdb_ready_i;
  // Flush and reset both suppress any acceptance in the current cycle.
  assign load_ok  = can_load && !flush_i && !rst_i;
  assign transfer = grant_found && load_ok;

  // Rotating search: first valid requester at or after rr_ptr_q, modulo EU_N.
  always_comb begin
    // NOTE: every variable driven here gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    search_sum  = '0;
    search_idx  = '0;
    for (int i = 0; i < EU_N; i++) begin
      // NOTE: blocking assignments are correct inside combinational logic;
      // each iteration must see the value computed just above it.
      search_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (search_sum >= (PTR_W+1)'(EU_N)) begin
        search_sum = search_sum - (PTR_W+1)'(EU_N);
      end
      search_idx = search_sum[PTR_W-1:0];
      if (!grant_found && eu_valid_i[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  // One-hot accept toward the winning execution unit, only when it can land.
  always_comb begin
    eu_ready_o = '0;
    if (transfer) begin
      eu_ready_o[grant_idx] = 1'b1;
    end
  end

  // Output register and priority pointer; flush wins over load, load over drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from the values sampled at the clock edge.
      if (flush_i) begin
        cdb_valid_q <= 1'b0;
      end else if (transfer) begin
        cdb_data_q  <= eu_data_i[grant_idx];
        cdb_valid_q <= 1'b1;
        rr_ptr_q    <= (grant_idx == PTR_W'(EU_N-1)) ? '0 : grant_idx + PTR_W'(1);
      end else if (cdb_valid_q && cdb_ready_i) begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_data_o  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the bus.

module tb_cdb_arbiter;

  localparam int EU_N  = 7;
  localparam int CDB_W = $bits(cdb_pkg::cdb_data_t);

  logic                       clk;
  logic                       rst;
  logic                       flush;
  logic [EU_N-1:0]            eu_valid;
  logic [EU_N-1:0]            eu_ready;
  logic [EU_N-1:0][CDB_W-1:0] eu_data;
  logic                       cdb_valid;
  logic                       cdb_ready;
  logic [CDB_W-1:0]           cdb_data;

  int total = 0;
  int bad   = 0;

  // Model of the bus: priority index, broadcast register valid and payload.
  int               m_ptr;
  bit               m_valid;
  logic [CDB_W-1:0] m_data;

  cdb_arbiter #(.EU_N(EU_N), .CDB_W(CDB_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .eu_valid_i  (eu_valid),
    .eu_ready_o  (eu_ready),
    .eu_data_i   (eu_data),
    .cdb_valid_o (cdb_valid),
    .cdb_ready_i (cdb_ready),
    .cdb_data_o  (cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CDB_W-1:0] rand_payload();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CDB_W-1:0];
  endfunction

  function automatic int pick(input logic [EU_N-1:0] v);
    for (int k = 0; k < EU_N; k++) begin
      int e;
      e = (m_ptr + k) % EU_N;
      if (v[e]) return e;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_data  = '0;
  endtask

  // One cycle: drive inputs, check the accept vector, clock, check the broadcast.
  // g returns the EU that actually transferred, or -1.
  task automatic step(input logic [EU_N-1:0] v, input logic rdy, input logic fl,
                      output int g);
    logic [EU_N-1:0] exp_ready;
    int              w;
    eu_valid  = v;
    cdb_ready = rdy;
    flush     = fl;
    #1;
    w         = pick(v);
    exp_ready = '0;
    g         = -1;
    if (w >= 0 && (!m_valid || rdy) && !fl) begin
      exp_ready[w] = 1'b1;
      g            = w;
    end
    check("eu_ready", eu_ready, exp_ready);
    if (fl) begin
      m_valid = 0;
    end else if (g >= 0) begin
      m_data  = eu_data[g];
      m_valid = 1;
      m_ptr   = (g + 1) % EU_N;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check("cdb_valid", cdb_valid, m_valid);
    if (m_valid) check("cdb_data", cdb_data, m_data);
  endtask

  initial begin
    cdb_pkg::cdb_data_t d;
    logic [EU_N-1:0]    pend;
    int                 waited [EU_N];
    int                 g;
    logic [EU_N-1:0]    drop;

    rst       = 1'b1;
    flush     = 1'b0;
    cdb_ready = 1'b1;
    eu_valid  = 7'b0001000;
    for (int i = 0; i < EU_N; i++) eu_data[i] = rand_payload();
    model_reset();

    // Outputs stay quiet while reset is held, even with a request present.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", cdb_valid, 0);
    check("rst_data", cdb_data, 0);
    check("rst_ready", eu_ready, 0);
    rst = 1'b0;

    // ALU request right after reset.
    d = '0;
    d.rob_idx   = 4'd5;
    d.res_value = $urandom();
    eu_data[3]  = d;
    eu_valid    = 7'b0001000;
    #1;
    check("alu_ready", eu_ready, 7'b0001000);
    step(7'b0001000, 1'b1, 1'b0, g);
    d = cdb_data;
    check("alu_rob", d.rob_idx, 5);

    // Asynchronous reset mid-cycle while a result is registered.
    eu_valid = '1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", cdb_valid, 0);
    check("arst_ready", eu_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("arst_hold", cdb_valid, 0);
    rst = 1'b0;

    // Everybody requesting: grants rotate 0..6 then back to 0.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < EU_N; i++) eu_data[i] = rand_payload();
      step('1, 1'b1, 1'b0, g);
      check("rr_order", g, k % EU_N);
    end

    // Wrap and skip: move the pointer to 6 first.
    step(7'b0100000, 1'b1, 1'b0, g);
    check("to_ptr6", g, 5);
    step(7'b0000101, 1'b1, 1'b0, g);
    check("wrap_g0", g, 0);
    step(7'b0000101, 1'b1, 1'b0, g);
    check("skip_g2", g, 2);

    // Backpressure: three stalled cycles, then back-to-back resume.
    step('1, 1'b1, 1'b0, g);
    check("bp_first", g, 3);
    d = cdb_data;
    for (int k = 0; k < 3; k++) begin
      step('1, 1'b0, 1'b0, g);
      check("bp_stall", eu_ready, 0);
      check("bp_hold", cdb_data, d);
    end
    step('1, 1'b1, 1'b0, g);
    check("bp_resume", g, 4);
    step('1, 1'b1, 1'b0, g);
    check("bp_next", g, 5);

    // Flush beats the grant; EU 2 wins once flush is gone.
    step(7'b0000100, 1'b1, 1'b1, g);
    check("fl_block", g, -1);
    check("fl_valid", cdb_valid, 0);
    step(7'b0000100, 1'b1, 1'b0, g);
    check("fl_after", g, 2);

    // Idle: no requests for 10 cycles, pointer must not move.
    for (int k = 0; k < 10; k++) step('0, 1'b1, 1'b0, g);
    check("idle_valid", cdb_valid, 0);
    step('1, 1'b1, 1'b0, g);
    check("idle_ptr", g, 3);

    // Randomized traffic in phases of light/heavy load and stall rate.
    pend = '0;
    for (int i = 0; i < EU_N; i++) waited[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      int  phase;
      int  load_pct;
      int  rdy_pct;
      bit  rdy;
      bit  fl;
      phase    = n / 500;
      load_pct = (phase % 2 == 1) ? 90 : 35;
      rdy_pct  = (phase == 2) ? 30 : 75;
      for (int i = 0; i < EU_N; i++) begin
        if (!pend[i] && $urandom_range(99) < load_pct) begin
          pend[i]    = 1'b1;
          eu_data[i] = rand_payload();
          waited[i]  = 0;
        end
      end
      rdy = ($urandom_range(99) < rdy_pct);
      fl  = ($urandom_range(99) < 5);
      step(pend, rdy, fl, g);
      if (g >= 0) begin
        check("starve", (waited[g] <= EU_N - 1), 1);
        pend[g] = 1'b0;
        for (int i = 0; i < EU_N; i++) if (pend[i]) waited[i]++;
      end
      if (fl) begin
        drop = EU_N'($urandom());
        pend = pend & ~drop;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
